// File: rtl/pc_pkg.sv
// Shared definitions for the program counter slice: operation encoding,
// request priority decode and the zero-extension helper width.
package pc_pkg;

    // Widest bus the zero-extension path supports.
    localparam int unsigned PC_ZEXT_W = 32;

    typedef enum logic [2:0] {
        PC_HOLD = 3'd0,
        PC_INC  = 3'd1,
        PC_LOAD = 3'd2,
        PC_CALL = 3'd3,
        PC_RET  = 3'd4
    } pc_op_t;

    // One operation per cycle: halt > ret > call > load > inc > hold.
    function automatic pc_op_t pc_decode(
        input logic halt,
        input logic ret,
        input logic call,
        input logic load,
        input logic inc
    );
        if (halt)      return PC_HOLD;
        else if (ret)  return PC_RET;
        else if (call) return PC_CALL;
        else if (load) return PC_LOAD;
        else if (inc)  return PC_INC;
        else           return PC_HOLD;
    endfunction

endpackage

// File: rtl/pc_unit_if.sv
// Control/bus bundle between the sequencer (master) and the program counter (slave).
interface pc_unit_if #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned BUS_W  = 8
);
    logic              halt;
    logic              inc;
    logic              load;
    logic              call;
    logic              ret;
    logic              out_en;
    logic [BUS_W-1:0]  bus_in;
    logic [BUS_W-1:0]  bus_out;
    logic [ADDR_W-1:0] pc;
    logic              wrap;
    logic              stack_err;

    modport master (
        output halt, inc, load, call, ret, out_en, bus_in,
        input  bus_out, pc, wrap, stack_err
    );

    modport slave (
        input  halt, inc, load, call, ret, out_en, bus_in,
        output bus_out, pc, wrap, stack_err
    );
endinterface

// File: rtl/pc_ret_stack.sv
// Return-address LIFO: DEPTH entries of ADDR_W bits. Only the pointer is
// reset; entries above the pointer are never read, so storage needs no reset.
module pc_ret_stack #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_data,
    output logic [ADDR_W-1:0] top_data,
    output logic              full,
    output logic              empty
);
    localparam int unsigned SP_W = $clog2(DEPTH + 1);

    logic [SP_W-1:0]   sp_q;
    logic [ADDR_W-1:0] mem [DEPTH];

    assign full  = (sp_q == SP_W'(DEPTH));
    assign empty = (sp_q == '0);

    // Stack pointer: count of valid entries, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sp_q <= '0;
        end else if (push && !full) begin
            sp_q <= sp_q + SP_W'(1);
        end else if (pop && !empty) begin
            sp_q <= sp_q - SP_W'(1);
        end
    end

    // Entry storage: write the slot the pointer currently addresses.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (push && !full && (SP_W'(i) == sp_q)) begin
                mem[i] <= push_data;
            end
        end
    end

    // Top-of-stack read: entry just below the pointer.
    always_comb begin
        top_data = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (SP_W'(i + 1) == sp_q) begin
                top_data = mem[i];
            end
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Program counter for the SAP-style core: increment, load from bus, drive onto
// bus, wrap pulse. Define PC_STACK_EN to build the call/return stack; without
// it call behaves as load, ret is ignored and stack_err is tied low.
module pc_unit
    import pc_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 4,
    parameter int unsigned       BUS_W     = 8,
    parameter int unsigned       DEPTH     = 4,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0
) (
    input logic      clk,
    input logic      rst,
    pc_unit_if.slave bif
);
    logic [ADDR_W-1:0]    pc_q;
    logic [ADDR_W-1:0]    pc_d;
    logic [ADDR_W-1:0]    pc_inc;
    logic [ADDR_W-1:0]    bus_addr;
    logic                 wrap_q;
    logic                 wrap_d;
    logic                 ret_req;
    logic [PC_ZEXT_W-1:0] pc_wide;
    logic                 unused_cfg;
    pc_op_t               op;

    assign pc_inc   = pc_q + ADDR_W'(1);
    assign bus_addr = bif.bus_in[ADDR_W-1:0];

`ifdef PC_STACK_EN
    logic              st_full;
    logic              st_empty;
    logic              st_push;
    logic              st_pop;
    logic [ADDR_W-1:0] st_top;
    logic              err_q;
    logic              err_d;

    assign ret_req = bif.ret;
    assign st_push = (op == PC_CALL) && !st_full;
    assign st_pop  = (op == PC_RET) && !st_empty;

    pc_ret_stack #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_stack (
        .clk       (clk),
        .rst       (rst),
        .push      (st_push),
        .pop       (st_pop),
        .push_data (pc_inc),
        .top_data  (st_top),
        .full      (st_full),
        .empty     (st_empty)
    );

    // Sticky error: call on a full stack or ret on an empty one.
    always_comb begin
        err_d = err_q
              | ((op == PC_CALL) && st_full)
              | ((op == PC_RET) && st_empty);
    end

    // Error flag register, cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign bif.stack_err = err_q;
`else
    // ret is dropped before decode so it cannot shadow a same-cycle call.
    assign ret_req       = 1'b0;
    assign bif.stack_err = 1'b0;
`endif

    // Resolve the simultaneous requests into a single operation.
    always_comb begin
        op = pc_decode(bif.halt, ret_req, bif.call, bif.load, bif.inc);
    end

    // Next PC and wrap pulse for the selected operation.
    always_comb begin
        pc_d   = pc_q;
        wrap_d = 1'b0;
        unique case (op)
            PC_INC: begin
                pc_d   = pc_inc;
                wrap_d = &pc_q;
            end
            PC_LOAD: pc_d = bus_addr;
`ifdef PC_STACK_EN
            PC_CALL: if (!st_full) pc_d = bus_addr;
            PC_RET:  if (!st_empty) pc_d = st_top;
`else
            PC_CALL: pc_d = bus_addr;
            PC_RET:  pc_d = pc_q;
`endif
            default: pc_d = pc_q;
        endcase
    end

    // PC and wrap registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q   <= RESET_VEC;
            wrap_q <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            wrap_q <= wrap_d;
        end
    end

    assign pc_wide     = PC_ZEXT_W'(pc_q);
    assign bif.bus_out = bif.out_en ? pc_wide[BUS_W-1:0] : 'z;
    assign bif.pc      = pc_q;
    assign bif.wrap    = wrap_q;

    assign unused_cfg = ^{(DEPTH == 0), bif.ret, bif.bus_in, pc_wide};

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program counter for the SAP-style CPU core: holds the instruction address, increments, loads jump targets from the shared bus, and drives its value back onto the bus under control-word enable. It adds synchronous clocking, parametrised address/bus widths, a halt input, wrap detection and an optional hardware return-address stack for call/return. It sits between the control sequencer (which issues `inc`/`load`/`call`/`ret`/`out_en`) and the 8-bit shared bus feeding the memory address register.

## Interface
- `ADDR_W`, 4: PC width in bits; must satisfy 1 ≤ `ADDR_W` ≤ `BUS_W`.
- `BUS_W`, 8: shared bus width.
- `DEPTH`, 4: return-stack entries, minimum 1; ignored when the stack is compiled out.
- `RESET_VEC`, 0: PC value after reset, `ADDR_W` bits.

- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `halt`  in  1  freezes PC and stack while high.
- `inc`  in  1  increment PC.
- `load`  in  1  load PC from `bus_in[ADDR_W-1:0]`.
- `call`  in  1  push PC+1, then load PC from `bus_in`; stack build only.
- `ret`  in  1  pop the stack into PC; stack build only.
- `out_en`  in  1  drive the PC onto `bus_out`.
- `bus_in`  in  `BUS_W`  shared bus value.
- `bus_out`  out  `BUS_W`  zero-extended PC when `out_en` is high, otherwise all Z.
- `pc`  out  `ADDR_W`  current PC, always driven.
- `wrap`  out  1  one-cycle pulse when an increment rolls over from all-ones to 0.
- `stack_err`  out  1  sticky overflow/underflow flag; cleared only by reset.

## Operation
- Reset (`rst`=0, applied asynchronously): `pc`=`RESET_VEC`, `wrap`=0, `stack_err`=0, stack pointer=0 (empty). `bus_out` follows `out_en` even during reset.
- One operation per cycle. Priority is `halt` > `ret` > `call` > `load` > `inc` > hold. Lower-priority requests in the same cycle are dropped and are not queued.
- `inc`: `pc` ← `pc`+1, modulo 2^`ADDR_W`. At all-ones, `pc` becomes 0 and `wrap`=1 for exactly that next cycle.
- `load`: `pc` ← `bus_in[ADDR_W-1:0]`; upper bus bits are ignored. `wrap`=0.
- `call`:
  - Stack not full: push (`pc`+1) mod 2^`ADDR_W`, then `pc` ← `bus_in[ADDR_W-1:0]`.
  - Stack full (`DEPTH` entries): no push, no jump, `pc` holds, `stack_err` ← 1.
- `ret`:
  - Stack not empty: `pc` ← top entry, then pop.
  - Stack empty: `pc` holds, `stack_err` ← 1.
- `halt`: every request is ignored and `pc`, the stack and `stack_err` hold. `wrap` returns to 0.
- `bus_out` is combinational from the registered `pc` and `out_en`, zero-extended in the upper `BUS_W-ADDR_W` bits. `out_en` has no effect on the state.
- Reset asserted in the middle of an operation wins immediately; the stack contents are discarded through the pointer reset.

## Timing
- Every update takes effect at the rising edge where the request is sampled. The new `pc` is visible after that edge, giving 1-cycle latency.
- `bus_out` changes in the same cycle as `out_en`, through a zero-cycle combinational path; there is no register stage.
- `wrap` is registered: it is high for the cycle after the rolling edge only.
- `stack_err` rises in the cycle after the offending request and then stays high.
- Back-to-back `call` then `ret` on consecutive cycles returns to the caller's PC+1. The return path has no bubble.

## Configuration
- `PC_STACK_EN`:
  - Defined: the `DEPTH`-entry return stack is built, and `call`/`ret` behave as described above.
  - Undefined: no stack storage is built. `call` acts as `load` (same priority slot) and `ret` is ignored. `stack_err` is tied to 0, and `DEPTH` is unused.

## Structure
- Shared package `pc_pkg`:
  - Operation enum `pc_op_t` = {`PC_HOLD`, `PC_INC`, `PC_LOAD`, `PC_CALL`, `PC_RET`}.
  - Priority-decode function mapping (`halt`, `ret`, `call`, `load`, `inc`) to `pc_op_t`.
  - Constant for the zero-extension helper width.
- Sub-module `pc_ret_stack` is natural: a LIFO of `DEPTH` × `ADDR_W` with push/pop, `full`/`empty` outputs and an async active-low reset of its pointer. It is instantiated only under `PC_STACK_EN`.

## Test plan
- Reset, then 16 × `inc` with `ADDR_W`=4: `pc` goes 0→15→0, and `wrap`=1 only in the cycle after the 15→0 edge.
- `load` with `bus_in`=0xA7 and `ADDR_W`=4: `pc`=0x7. Then `out_en`=1 gives `bus_out`=0x07, and `out_en`=0 gives `bus_out`=Z.
- `inc`+`load`+`halt` in the same cycle with `pc`=3: `pc` stays 3. `inc`+`load` (bus 9) with `pc`=3: `pc`=9.
- Stack build, `DEPTH`=2, from `pc`=1:
  - `call` 5: `pc`=5.
  - `call` 8: `pc`=8.
  - Third `call` C: `pc` stays 8 and `stack_err`=1.
  - `ret`: `pc`=6. `ret` again: `pc`=2.
  - Another `ret` on the empty stack: `pc` stays 2.
- Assert `rst` asynchronously mid-cycle with `pc`=9 and one stack entry: `pc`=`RESET_VEC` before the next edge, the stack is empty, and `stack_err`=0.
- Without `PC_STACK_EN`: `call` with bus 4 gives `pc`=4, `ret` leaves `pc` unchanged, and `stack_err` stays 0.
